dco_period_meter: RTL and testbench
===================================

DCO_PERIOD_METER -- requirements
Module: dco_period_meter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth for sig_in (legal 2..3).
REQ-002 Parameter LOCK_COUNT, default 4, number of consecutive equal decoded codes required for lock (legal 1..15).
REQ-003 Parameter TIMEOUT, default 255, clk cycles without a sig_in edge before loss-of-signal (legal 52..255).
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ena  in  1  block enable; low freezes measurement.
REQ-007 clr  in  1  synchronous clear of measurement state, active-high.
REQ-008 sig_in  in  1  asynchronous square wave from a DCO output pin.
REQ-009 code_out  out  8  decoded one-hot DCO code of the last valid measurement.
REQ-010 half_period  out  8  last captured edge-to-edge interval in clk cycles, saturating at 255.
REQ-011 code_valid  out  1  one-cycle pulse when code_out is updated.
REQ-012 locked  out  1  level; LOCK_COUNT consecutive equal codes seen.
REQ-013 err  out  1  one-cycle pulse when a captured interval matches no table entry.
REQ-014 timeout  out  1  level; no edge for TIMEOUT cycles.

Function
REQ-015 sig_in SHALL pass through SYNC_STAGES flops; both rising and falling edges of the synchronized signal count as edges; synchronizer latency is constant and does not alter intervals.
REQ-016 Interval counter SHALL load 1 on each edge and increment by 1 per cycle, saturating at 255; on the next edge its value is captured into half_period.
REQ-017 Decode table (interval -> code_out): 11->8'h80, 10->8'h40, 9->8'h20, 8->8'h10, 7->8'h08, 6->8'h04, 5->8'h02, 4->8'h01, 51->8'h00; any other interval is unmatched.
REQ-018 FSM states IDLE, MEASURE, LOCKED; reset and clr enter IDLE.
REQ-019 IDLE: first edge starts the counter and moves to MEASURE; no interval is captured (partial interval discarded).
REQ-020 MEASURE/LOCKED: each edge captures the interval; code_out, code_valid and err update in the cycle after the edge is detected (latency 1 cycle from edge detect).
REQ-021 Matched interval: code_out <= decoded code, code_valid pulses; match counter increments if code equals previous decoded code, else reloads to 1.
REQ-022 Match counter reaching LOCK_COUNT SHALL move MEASURE->LOCKED and set locked; counter saturates at LOCK_COUNT.
REQ-023 Unmatched interval: err pulses, code_out holds, match counter clears, LOCKED->MEASURE, locked clears the same cycle err asserts.
REQ-024 Matched code differing from the locked code SHALL clear locked and return to MEASURE with match counter = 1.
REQ-025 Counter reaching TIMEOUT without an edge: timeout=1, locked=0, code_out=8'h00, state IDLE; timeout clears on the next edge.
REQ-026 ena low: FSM, counters and outputs hold; synchronizer keeps running; edges are ignored; on ena returning high the state SHALL go to IDLE (locked and code_out preserved until next decision).
REQ-027 clr and an edge in the same cycle: clr wins, edge discarded.
REQ-028 Interval counter saturation at 255 SHALL never wrap to 0.

Reset
REQ-029 rst_n low asynchronously: state IDLE, code_out=8'h00, half_period=8'h00, code_valid=0, locked=0, err=0, timeout=0, match counter 0, synchronizer flops 0.
REQ-030 Reset deassertion mid-waveform SHALL treat the first synchronized edge as an IDLE start edge.
REQ-031 clr SHALL produce the same register values as reset, one cycle after assertion.

Structure
REQ-032 Shared package dco_pkg SHALL hold the interval/code table constants, the no-signal interval (51) and the FSM state enum, shared with the DCO generator.
REQ-033 Sub-module sync_edge_det (SYNC_STAGES-flop synchronizer plus any-edge pulse) SHALL be instantiated once.
REQ-034 Decode table SHALL be a pure function in dco_pkg; no latches, single clock domain after the synchronizer.

Verification
REQ-035 sig_in toggling every 11 cycles -> code_out=8'h80 with code_valid per edge; locked=1 after the 4th captured interval.
REQ-036 toggling every 4 cycles then every 51 cycles -> lock on 8'h01, locked drops at first 51 interval, relock on 8'h00 after 4 intervals.
REQ-037 toggling every 20 cycles -> err pulse per edge, code_valid never, locked stays 0, half_period=20.
REQ-038 lock on 8'h10 then hold sig_in static -> timeout=1 and code_out=8'h00 exactly 255 cycles after the last edge counter load.
REQ-039 rst_n pulsed low while LOCKED (and separately clr coincident with an edge) -> all outputs at reset values; relock requires 1 start edge + 4 intervals.
REQ-040 ena low for 30 cycles during toggling every 7 cycles -> outputs frozen, no code_valid; after ena high, first edge restarts, relock on 8'h08.

Source files
------------

// File: rtl/dco_pkg.sv
// Definitions shared by the DCO generator and the DCO period meter:
// half-period/code table, no-signal interval, FSM states and the table decoder.
package dco_pkg;

  localparam logic [7:0] IV_CODE0     = 8'd4;
  localparam logic [7:0] IV_CODE1     = 8'd5;
  localparam logic [7:0] IV_CODE2     = 8'd6;
  localparam logic [7:0] IV_CODE3     = 8'd7;
  localparam logic [7:0] IV_CODE4     = 8'd8;
  localparam logic [7:0] IV_CODE5     = 8'd9;
  localparam logic [7:0] IV_CODE6     = 8'd10;
  localparam logic [7:0] IV_CODE7     = 8'd11;
  localparam logic [7:0] IV_NO_SIGNAL = 8'd51;

  localparam logic [7:0] CODE0          = 8'h01;
  localparam logic [7:0] CODE1          = 8'h02;
  localparam logic [7:0] CODE2          = 8'h04;
  localparam logic [7:0] CODE3          = 8'h08;
  localparam logic [7:0] CODE4          = 8'h10;
  localparam logic [7:0] CODE5          = 8'h20;
  localparam logic [7:0] CODE6          = 8'h40;
  localparam logic [7:0] CODE7          = 8'h80;
  localparam logic [7:0] CODE_NO_SIGNAL = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } dco_state_e;

  typedef struct packed {
    logic       hit;
    logic [7:0] code;
  } dco_decode_t;

  function automatic dco_decode_t decode_interval(input logic [7:0] interval);
    dco_decode_t d;
    d.hit  = 1'b1;
    d.code = CODE_NO_SIGNAL;
    case (interval)
      IV_CODE0:     d.code = CODE0;
      IV_CODE1:     d.code = CODE1;
      IV_CODE2:     d.code = CODE2;
      IV_CODE3:     d.code = CODE3;
      IV_CODE4:     d.code = CODE4;
      IV_CODE5:     d.code = CODE5;
      IV_CODE6:     d.code = CODE6;
      IV_CODE7:     d.code = CODE7;
      IV_NO_SIGNAL: d.code = CODE_NO_SIGNAL;
      default: begin
        d.hit  = 1'b0;
        d.code = CODE_NO_SIGNAL;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input plus a one-cycle pulse
// on every rising or falling edge of the synchronized level.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic any_edge
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchronizer chain and previous-level flop; clr restarts from a known low level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else if (clr) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign any_edge = sync_r[STAGES-1] ^ prev_r;

endmodule

// File: rtl/dco_period_meter.sv
// Measures the edge-to-edge interval of a DCO output, decodes it to the
// one-hot DCO code, and tracks lock, decode errors and loss of signal.
module dco_period_meter
  import dco_pkg::*;
#(
  parameter int SYNC_STAGES = 32'sd2,
  parameter int LOCK_COUNT  = 32'sd4,
  parameter int TIMEOUT     = 32'sd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       clr,
  input  logic       sig_in,
  output logic [7:0] code_out,
  output logic [7:0] half_period,
  output logic       code_valid,
  output logic       locked,
  output logic       err,
  output logic       timeout
);

  localparam logic [3:0] LOCK_CNT    = 4'(LOCK_COUNT);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  dco_state_e  state_r, state_n, cur_state;
  logic        ena_d_r;
  logic [7:0]  cnt_r, cnt_n;
  logic [3:0]  match_r, match_n, match_inc;
  logic [7:0]  code_r, code_n;
  logic [7:0]  hp_r, hp_n;
  logic        valid_r, valid_n;
  logic        err_r, err_n;
  logic        locked_r, locked_n;
  logic        tmo_r, tmo_n;
  logic        any_edge;
  dco_decode_t dec;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .d        (sig_in),
    .any_edge (any_edge)
  );

  // The first enabled cycle after a freeze behaves as IDLE so stale intervals are never captured.
  assign cur_state = ena_d_r ? state_r : ST_IDLE;
  assign dec       = decode_interval(cnt_r);
  assign match_inc = (match_r >= LOCK_CNT) ? LOCK_CNT : match_r + 4'd1;

  // Next-state, interval counter and output decisions.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    match_n  = match_r;
    code_n   = code_r;
    hp_n     = hp_r;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    locked_n = locked_r;
    tmo_n    = tmo_r;
    if (!ena) begin
      state_n = state_r;
    end else if (any_edge) begin
      cnt_n = 8'd1;
      tmo_n = 1'b0;
      case (cur_state)
        ST_IDLE: begin
          state_n = ST_MEASURE;
          match_n = 4'd0;
        end
        ST_MEASURE, ST_LOCKED: begin
          hp_n = cnt_r;
          if (dec.hit) begin
            code_n   = dec.code;
            valid_n  = 1'b1;
            match_n  = (dec.code == code_r) ? match_inc : 4'd1;
            locked_n = (match_n == LOCK_CNT);
            state_n  = locked_n ? ST_LOCKED : ST_MEASURE;
          end else begin
            err_n    = 1'b1;
            match_n  = 4'd0;
            locked_n = 1'b0;
            state_n  = ST_MEASURE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end else if ((cur_state != ST_IDLE) && (cnt_r == TIMEOUT_CNT)) begin
      tmo_n    = 1'b1;
      locked_n = 1'b0;
      code_n   = CODE_NO_SIGNAL;
      match_n  = 4'd0;
      state_n  = ST_IDLE;
    end else if (cur_state != ST_IDLE) begin
      state_n = cur_state;
      cnt_n   = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
    end else begin
      state_n = ST_IDLE;
    end
  end

  // State and registered outputs; clr gives the same values as reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      ena_d_r  <= 1'b0;
      cnt_r    <= 8'd0;
      match_r  <= 4'd0;
      code_r   <= 8'h00;
      hp_r     <= 8'h00;
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
      locked_r <= 1'b0;
      tmo_r    <= 1'b0;
    end else if (clr) begin
      state_r  <= ST_IDLE;
      ena_d_r  <= 1'b0;
      cnt_r    <= 8'd0;
      match_r  <= 4'd0;
      code_r   <= 8'h00;
      hp_r     <= 8'h00;
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
      locked_r <= 1'b0;
      tmo_r    <= 1'b0;
    end else begin
      state_r  <= state_n;
      ena_d_r  <= ena;
      cnt_r    <= cnt_n;
      match_r  <= match_n;
      code_r   <= code_n;
      hp_r     <= hp_n;
      valid_r  <= valid_n;
      err_r    <= err_n;
      locked_r <= locked_n;
      tmo_r    <= tmo_n;
    end
  end

  assign code_out    = code_r;
  assign half_period = hp_r;
  assign code_valid  = valid_r;
  assign locked      = locked_r;
  assign err         = err_r;
  assign timeout     = tmo_r;

endmodule

// File: tb/tb_dco_period_meter.sv
// Randomized and directed bench for dco_period_meter, checked every cycle
// against a timestamp-based reference model of the measurement rules.
module tb_dco_period_meter;

  localparam int S  = 2;
  localparam int LC = 4;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       rst_n, ena, clr, sig_in;
  logic [7:0] code_out, half_period;
  logic       code_valid, locked, err, timeout;

  dco_period_meter #(
    .SYNC_STAGES (S),
    .LOCK_COUNT  (LC),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .clr         (clr),
    .sig_in      (sig_in),
    .code_out    (code_out),
    .half_period (half_period),
    .code_valid  (code_valid),
    .locked      (locked),
    .err         (err),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int         n = 0;
  int         zero_upto = 0;
  bit         s_hist [0:65535];
  bit         m_idle = 1'b1;
  bit         m_resume = 1'b0;
  int         m_last = 0;
  int         m_run = 0;
  logic [7:0] m_code = 8'h00;
  logic [7:0] m_hp = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_err = 1'b0;
  bit         m_locked = 1'b0;
  bit         m_tmo = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic bit val(int j);
    if (j < 0 || j <= zero_upto) return 1'b0;
    return s_hist[j];
  endfunction

  // Model update for the clock edge numbered n, using the inputs present at that edge.
  task automatic model_step();
    bit         e, hit, st_idle;
    int         iv;
    logic [7:0] c;
    n++;
    s_hist[n] = sig_in;
    if (!rst_n || clr) begin
      zero_upto = n;
      m_idle = 1'b1; m_resume = 1'b0; m_last = 0; m_run = 0;
      m_code = 8'h00; m_hp = 8'h00; m_valid = 1'b0; m_err = 1'b0;
      m_locked = 1'b0; m_tmo = 1'b0;
      return;
    end
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!ena) begin
      m_resume = 1'b1;
      return;
    end
    st_idle  = m_idle || m_resume;
    m_resume = 1'b0;
    e = (val(n - S) != val(n - S - 1));
    if (e) begin
      m_tmo = 1'b0;
      if (st_idle) begin
        m_idle = 1'b0;
        m_last = n;
        m_run  = 0;
      end else begin
        iv = n - m_last;
        if (iv > 255) iv = 255;
        m_last = n;
        m_hp   = 8'(iv);
        hit = 1'b1;
        if (iv >= 4 && iv <= 11) c = 8'(1 << (iv - 4));
        else if (iv == 51) c = 8'h00;
        else begin hit = 1'b0; c = 8'h00; end
        if (hit) begin
          m_run    = (c == m_code) ? ((m_run + 1 > LC) ? LC : m_run + 1) : 1;
          m_code   = c;
          m_valid  = 1'b1;
          m_locked = (m_run == LC);
        end else begin
          m_err    = 1'b1;
          m_run    = 0;
          m_locked = 1'b0;
        end
      end
    end else if (!st_idle && (n - m_last) == TO) begin
      m_tmo = 1'b1; m_locked = 1'b0; m_code = 8'h00; m_idle = 1'b1; m_run = 0;
    end else begin
      m_idle = st_idle;
    end
  endtask

  task automatic compare_all();
    check_eq("code_out", code_out, m_code);
    check_eq("half_period", half_period, m_hp);
    check_eq("code_valid", code_valid, m_valid);
    check_eq("locked", locked, m_locked);
    check_eq("err", err, m_err);
    check_eq("timeout", timeout, m_tmo);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic toggle(input int period, input int edges);
    for (int k = 0; k < edges; k++) begin
      repeat (period) step();
      sig_in = ~sig_in;
    end
  endtask

  int sel, per, ne;

  initial begin
    rst_n = 1'b0; ena = 1'b1; clr = 1'b0; sig_in = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    check_eq("rst_code", code_out, 8'h00);
    check_eq("rst_locked", locked, 1'b0);

    // 11-cycle half period: lock on 0x80
    toggle(11, 6); repeat (4) step();
    check_eq("p11_code", code_out, 8'h80);
    check_eq("p11_locked", locked, 1'b1);

    // 4 then 51: lock on 0x01, relock on 0x00
    toggle(4, 8); toggle(51, 6); repeat (4) step();
    check_eq("p51_code", code_out, 8'h00);
    check_eq("p51_locked", locked, 1'b1);

    // 20: unmatched every edge
    toggle(20, 5); repeat (4) step();
    check_eq("p20_hp", half_period, 8'd20);
    check_eq("p20_locked", locked, 1'b0);

    // lock on 0x10, then static input until loss of signal
    toggle(8, 6); repeat (300) step();
    check_eq("tmo_flag", timeout, 1'b1);
    check_eq("tmo_code", code_out, 8'h00);

    // reset pulse while locked, then relock on 0x20
    toggle(6, 6); repeat (3) step();
    #2 rst_n = 1'b0;
    step();
    check_eq("rstpulse_locked", locked, 1'b0);
    rst_n = 1'b1;
    toggle(9, 6); repeat (4) step();
    check_eq("p9_code", code_out, 8'h20);
    check_eq("p9_locked", locked, 1'b1);

    // clr on the cycle an edge is processed
    toggle(10, 5);
    sig_in = ~sig_in;
    step(); step();
    clr = 1'b1; step(); clr = 1'b0;
    check_eq("clr_locked", locked, 1'b0);
    check_eq("clr_hp", half_period, 8'h00);
    repeat (12) step();

    // ena low for 30 cycles during 7-cycle toggling
    toggle(7, 6);
    ena = 1'b0; toggle(7, 4); repeat (2) step(); ena = 1'b1;
    toggle(7, 6); repeat (4) step();
    check_eq("p7_code", code_out, 8'h08);
    check_eq("p7_locked", locked, 1'b1);

    // randomized bursts
    for (int b = 0; b < 60; b++) begin
      sel = $urandom_range(0, 11);
      per = (sel < 8) ? sel + 4 : ((sel == 8) ? 51 : $urandom_range(1, 60));
      ne  = $urandom_range(2, 7);
      if ($urandom_range(0, 9) == 0) ena = 1'b0;
      toggle(per, ne);
      ena = 1'b1;
      if ($urandom_range(0, 9) == 0) begin clr = 1'b1; step(); clr = 1'b0; end
      if ($urandom_range(0, 14) == 0) repeat (260) step();
    end
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
